// File: rtl/gnrc_ram_master.sv
// Request/response initiator for one port of gnrc_true_dpram / gnrc_spram.
// Build option GNRC_RAM_MASTER_WRITE_ACK_EN: writes also return an in-order zero-data response.
module gnrc_ram_master #(
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 10,
    parameter int unsigned DELAY      = 1,
    parameter int unsigned BYTE_WRITE = 0,
    parameter int unsigned RSP_DEPTH  = DELAY + 1,
    localparam int unsigned WW        = (BYTE_WRITE != 0) ? DW / 8 : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [WW-1:0] req_we_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          ram_en_o,
    output logic [WW-1:0] ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_din_o,
    input  logic [DW-1:0] ram_dout_i
);

    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic             acc;
    logic             tag_in;
    logic             push;
    logic             pop;
    logic [DW-1:0]    push_data;
    logic [DELAY-1:0] tag_q, tag_d;
`ifdef GNRC_RAM_MASTER_WRITE_ACK_EN
    logic [DELAY-1:0] wrk_q, wrk_d;
`endif
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    fill_q, fill_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]    mem_q [RSP_DEPTH];
    logic [DW-1:0]    mem_d [RSP_DEPTH];

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rsp_valid_o = (fill_q != '0);
        rsp_rdata_o = mem_q[rd_ptr_q];
        pop         = rsp_valid_o & rsp_ready_i;
        // cnt_q counts pipeline plus FIFO, so a pop this cycle frees a credit immediately
        req_ready_o = rst_ni & ((cnt_q - CW'(pop)) < CW'(RSP_DEPTH));
        acc         = req_valid_i & req_ready_o;

        ram_en_o    = acc;
        ram_we_o    = acc ? req_we_i : '0;
        ram_addr_o  = req_addr_i;
        ram_din_o   = req_wdata_i;

`ifdef GNRC_RAM_MASTER_WRITE_ACK_EN
        tag_in      = acc;
        wrk_d       = DELAY'({wrk_q, acc & (req_we_i != '0)});
        push_data   = wrk_q[DELAY-1] ? '0 : ram_dout_i;
`else
        tag_in      = acc & (req_we_i == '0);
        push_data   = ram_dout_i;
`endif
        tag_d       = DELAY'({tag_q, tag_in});
        push        = tag_q[DELAY-1];

        cnt_d       = cnt_q + CW'(tag_in) - CW'(pop);
        fill_d      = fill_q + CW'(push) - CW'(pop);
        wr_ptr_d    = push ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop ? ptr_next(rd_ptr_q) : rd_ptr_q;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q    <= '0;
`ifdef GNRC_RAM_MASTER_WRITE_ACK_EN
            wrk_q    <= '0;
`endif
            cnt_q    <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tag_q    <= tag_d;
`ifdef GNRC_RAM_MASTER_WRITE_ACK_EN
            wrk_q    <= wrk_d;
`endif
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule
